// File: rtl/mem_access_unit.sv
// Memory stage: issues data-memory accesses over a req/ready handshake and stalls the pipe
// while one is in flight. Define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_regWrite,
  input  logic                    ex_memRead,
  input  logic                    ex_memWrite,
  input  logic [2:0]              ex_funct3,
  input  logic [4:0]              ex_rd,
  input  logic [DATA_WIDTH-1:0]   ex_ALU_result,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  output logic                    d_req,
  output logic                    d_we,
  output logic [ADDRESS_BITS-1:0] d_addr,
  output logic [3:0]              d_be,
  output logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic                    d_ready,
  input  logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_stall,
  output logic                    mem_misaligned,
  output logic                    mem_bus_error,
  output logic                    mem_regWrite,
  output logic                    mem_memRead,
  output logic [4:0]              mem_rd,
  output logic [DATA_WIDTH-1:0]   mem_memory_data,
  output logic [DATA_WIDTH-1:0]   mem_ALU_result
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                  state_q;
  logic                    req_q, we_q, bus_err_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   wdata_q, load_q;

  logic                    access, legal_f3, misaligned, bad, go;
  logic [ADDRESS_BITS-1:0] addr;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d, lane, load_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;
`endif

  // CORE is informational only; TIMEOUT_CYCLES is dead without the timeout feature.
  logic unused_cfg;
  assign unused_cfg = ^{CORE, TIMEOUT_CYCLES};

  assign addr   = ex_ALU_result[ADDRESS_BITS-1:0];
  assign access = ex_memRead | ex_memWrite;

  always_comb begin
    legal_f3   = 1'b1;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = ex_store_data;
    case (ex_funct3)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{ex_store_data[7:0]}};
      end
      3'b001, 3'b101: begin
        misaligned = addr[0];
        be_d       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{ex_store_data[15:0]}};
      end
      3'b010:  misaligned = (addr[1:0] != 2'b00);
      default: legal_f3 = 1'b0;
    endcase
    if (!ex_memWrite) wdata_d = '0;
  end

  assign bad = access & (~legal_f3 | misaligned);
  assign go  = access & ~bad;

  // Lane select uses the registered address; ex_* are frozen by the stall during WAIT.
  assign lane = d_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (ex_funct3)
      3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_d = {24'b0, lane[7:0]};
      3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_d = {16'b0, lane[15:0]};
      default: load_d = d_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
      bus_err_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (go) begin
            req_q   <= 1'b1;
            we_q    <= ex_memWrite;
            addr_q  <= addr;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            state_q <= StWait;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StWait: begin
          if (d_ready) begin
            req_q   <= 1'b0;
            if (!we_q) load_q <= load_d;
            state_q <= StDone;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            req_q     <= 1'b0;
            load_q    <= '0;
            bus_err_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign d_req           = req_q;
  assign d_we            = we_q;
  assign d_addr          = addr_q;
  assign d_be            = be_q;
  assign d_wdata         = wdata_q;
  assign mem_memory_data = load_q;
  assign mem_bus_error   = bus_err_q;

  assign mem_stall      = reset & (((state_q == StIdle) & go) | (state_q == StWait));
  assign mem_misaligned = bad;
  // An aborted access must not write back; bus_err_q is high exactly in its DONE cycle.
  assign mem_regWrite   = ex_regWrite & ~bad & ~bus_err_q;
  assign mem_memRead    = ex_memRead;
  assign mem_rd         = ex_rd;
  assign mem_ALU_result = ex_ALU_result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected requests and retirements,
// separate monitors check the memory bus and the MEM/WB-side outputs.
module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        regw;
    logic        memr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] alu;
    logic        mis;
    logic        berr;
    int          stalls;
  } ret_t;

  logic        clock, reset;
  logic        ex_regWrite, ex_memRead, ex_memWrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_ALU_result, ex_store_data;
  logic        d_req, d_we, d_ready;
  logic [19:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_stall, mem_misaligned, mem_bus_error;
  logic        mem_regWrite, mem_memRead;
  logic [4:0]  mem_rd;
  logic [31:0] mem_memory_data, mem_ALU_result;

  int   checks = 0;
  int   failures = 0;
  req_t req_q[$];
  ret_t ret_q[$];
  logic ex_valid = 1'b0;
  int   mem_wait = 0;
  logic [31:0] mem_rdata = '0;
  logic stray_ready = 1'b0;

  mem_access_unit #(
    .CORE          (0),
    .DATA_WIDTH    (32),
    .ADDRESS_BITS  (20),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_regWrite    (ex_regWrite),
    .ex_memRead     (ex_memRead),
    .ex_memWrite    (ex_memWrite),
    .ex_funct3      (ex_funct3),
    .ex_rd          (ex_rd),
    .ex_ALU_result  (ex_ALU_result),
    .ex_store_data  (ex_store_data),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_be           (d_be),
    .d_wdata        (d_wdata),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned),
    .mem_bus_error  (mem_bus_error),
    .mem_regWrite   (mem_regWrite),
    .mem_memRead    (mem_memRead),
    .mem_rd         (mem_rd),
    .mem_memory_data(mem_memory_data),
    .mem_ALU_result (mem_ALU_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_wait WAIT cycles; may drive a stray ready when idle.
  initial begin
    int wctr = 0;
    d_ready = 1'b0;
    d_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (d_req) begin
        if (wctr == mem_wait) begin
          d_ready = 1'b1;
          d_rdata = mem_rdata;
        end else begin
          d_ready = 1'b0;
          d_rdata = 32'h5A5A_5A5A;
          wctr++;
        end
      end else begin
        wctr    = 0;
        d_ready = stray_ready;
        d_rdata = stray_ready ? 32'hFFFF_FFFF : 32'h0;
      end
    end
  end

  // Bus monitor: checks each new request, then that it stays stable while pending.
  initial begin
    logic seen = 1'b0;
    req_t cur;
    forever begin
      @(negedge clock);
      if (reset && d_req) begin
        if (!seen) begin
          seen = 1'b1;
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected: got addr %h be %h, expected no request", d_addr, d_be);
            cur = '{d_we, d_addr, d_be, d_wdata};
          end else begin
            cur = req_q.pop_front();
            chk("req_we", 64'(d_we), 64'(cur.we));
            chk("req_addr", 64'(d_addr), 64'(cur.addr));
            chk("req_be", 64'(d_be), 64'(cur.be));
            chk("req_wdata", 64'(d_wdata), 64'(cur.wdata));
          end
        end else begin
          chk("req_hold", {7'b0, d_we, d_be, d_addr, d_wdata},
              {7'b0, cur.we, cur.be, cur.addr, cur.wdata});
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // Retire monitor: counts stall cycles and checks outputs when the instruction advances.
  initial begin
    int   stall_cnt = 0;
    ret_t r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        stall_cnt = 0;
      end else if (ex_valid) begin
        if (mem_stall) begin
          stall_cnt++;
        end else if (ret_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected: got rd %0d, expected no retirement", mem_rd);
          stall_cnt = 0;
        end else begin
          r = ret_q.pop_front();
          chk("ret_stalls", 64'(stall_cnt), 64'(r.stalls));
          chk("ret_regWrite", 64'(mem_regWrite), 64'(r.regw));
          chk("ret_memRead", 64'(mem_memRead), 64'(r.memr));
          chk("ret_rd", 64'(mem_rd), 64'(r.rd));
          chk("ret_data", 64'(mem_memory_data), 64'(r.data));
          chk("ret_alu", 64'(mem_ALU_result), 64'(r.alu));
          chk("ret_misaligned", 64'(mem_misaligned), 64'(r.mis));
          chk("ret_bus_error", 64'(mem_bus_error), 64'(r.berr));
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic apply(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
    ex_regWrite   = rw;
    ex_memRead    = mr;
    ex_memWrite   = mw;
    ex_funct3     = f3;
    ex_rd         = rd;
    ex_ALU_result = alu;
    ex_store_data = sd;
  endtask

  task automatic wait_retire();
    int n = 0;
    @(negedge clock);
    while (mem_stall && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (mem_stall) begin
      checks++;
      failures++;
      $display("FAIL stall_bound: got mem_stall=1 after %0d cycles, expected release", n);
    end
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    stray_ready = 1'b0;
  endtask

  task automatic run(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                     input logic [31:0] rdata, input int waits, input logic stray,
                     input logic [3:0] xbe, input logic [31:0] xwdata, input logic xregw,
                     input logic xmis, input logic xberr, input logic [31:0] xdata,
                     input int xstalls);
    apply(rw, mr, mw, f3, rd, alu, sd);
    mem_wait    = waits;
    mem_rdata   = rdata;
    stray_ready = stray;
    if ((mr || mw) && !xmis) req_q.push_back('{mw, alu[19:0], xbe, xwdata});
    ret_q.push_back('{xregw, mr, rd, xdata, alu, xmis, xberr, xstalls});
    ex_valid = 1'b1;
    wait_retire();
  endtask

  initial begin
    reset = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 3'b010, 5'd5, 32'h20, 32'h0);
    mem_wait  = 0;
    mem_rdata = 32'h1122_3344;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_stall", 64'(mem_stall), 64'(0));
    chk("rst_req", 64'(d_req), 64'(0));
    chk("rst_data", 64'(mem_memory_data), 64'(0));
    chk("rst_bus_error", 64'(mem_bus_error), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_q.push_back('{1'b0, 20'h20, 4'hF, 32'h0});
    ret_q.push_back('{1'b1, 1'b1, 5'd5, 32'h1122_3344, 32'h20, 1'b0, 1'b0, 2});
    ex_valid = 1'b1;
    wait_retire();

    // rw mr mw f3 rd alu sd rdata waits stray | be wdata regw mis berr data stalls
    run(1, 1, 0, 3'b000, 6, 32'h3, 0, 32'h80FF_1234, 0, 0, 4'h8, 0, 1, 0, 0, 32'hFFFF_FF80, 2);
    run(1, 1, 0, 3'b100, 6, 32'h3, 0, 32'h80FF_1234, 0, 0, 4'h8, 0, 1, 0, 0, 32'h0000_0080, 2);
    run(1, 1, 0, 3'b001, 7, 32'h2, 0, 32'h80FF_1234, 1, 0, 4'hC, 0, 1, 0, 0, 32'hFFFF_80FF, 3);
    run(1, 1, 0, 3'b101, 7, 32'h2, 0, 32'h80FF_1234, 0, 0, 4'hC, 0, 1, 0, 0, 32'h0000_80FF, 2);
    run(0, 0, 1, 3'b001, 0, 32'h2, 32'h0000_BEEF, 0, 3, 0, 4'hC, 32'hBEEF_BEEF, 0, 0, 0,
        32'h0000_80FF, 5);
    run(0, 0, 1, 3'b000, 0, 32'h1, 32'h1234_56A5, 0, 0, 0, 4'h2, 32'hA5A5_A5A5, 0, 0, 0,
        32'h0000_80FF, 2);
    run(1, 1, 0, 3'b010, 9, 32'h6, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 32'h0000_80FF, 0);
    run(1, 1, 0, 3'b001, 9, 32'h5, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 32'h0000_80FF, 0);
    run(1, 1, 0, 3'b011, 9, 32'h8, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 32'h0000_80FF, 0);
    run(1, 0, 0, 3'b011, 8, 32'hDEAD_BEEF, 0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 32'h0000_80FF, 0);
    run(1, 1, 0, 3'b010, 10, 32'h10, 0, 32'hCAFE_F00D, 0, 0, 4'hF, 0, 1, 0, 0,
        32'hCAFE_F00D, 2);
    run(0, 0, 1, 3'b010, 0, 32'h14, 32'h0102_0304, 0, 0, 0, 4'hF, 32'h0102_0304, 0, 0, 0,
        32'hCAFE_F00D, 2);
    run(1, 0, 0, 3'b000, 11, 32'h14, 0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 32'hCAFE_F00D, 0);
    run(1, 1, 0, 3'b010, 12, 32'h18, 0, 32'h0BAD_F00D, 3, 0, 4'hF, 0, 1, 0, 0,
        32'h0BAD_F00D, 5);

`ifdef MEM_TIMEOUT_EN
    run(1, 1, 0, 3'b010, 13, 32'h24, 0, 32'h7777_7777, 1000000, 0, 4'hF, 0, 0, 0, 1,
        32'h0, 5);
    @(negedge clock);
    chk("bus_error_pulse", 64'(mem_bus_error), 64'(0));
    @(posedge clock);
    #1;
`endif

    // Reset in the middle of WAIT must drop the request at once.
    apply(1'b1, 1'b1, 1'b0, 3'b010, 5'd14, 32'h28, 32'h0);
    mem_wait = 1000000;
    req_q.push_back('{1'b0, 20'h28, 4'hF, 32'h0});
    ex_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_req", 64'(d_req), 64'(0));
    chk("midrst_stall", 64'(mem_stall), 64'(0));
    chk("midrst_data", 64'(mem_memory_data), 64'(0));
    ex_valid = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    #10 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_req", 64'(d_req), 64'(0));

    chk("req_queue_drained", 64'(req_q.size()), 64'(0));
    chk("ret_queue_drained", 64'(ret_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 5-stage core.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Consumes ALU result, store data and control bits.
- Performs loads and stores against the data memory over a req/ready handshake, stalling upstream stages while an access is outstanding.
- Produces regWrite, memRead, rd, extended load data and the pass-through ALU result consumed by MEM/WB.

Parameters:
- CORE, 0, core index; carried for multi-core instantiation, no functional effect.
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDRESS_BITS, 20, byte-address width presented to data memory.
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit (used only with MEM_TIMEOUT_EN).

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ex_regWrite  in  1  instruction writes rd
- ex_memRead  in  1  load instruction
- ex_memWrite  in  1  store instruction
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_rd  in  5  destination register
- ex_ALU_result  in  DATA_WIDTH  effective byte address or pass-through result
- ex_store_data  in  DATA_WIDTH  rs2 value for stores
- d_req  out  1  memory request (registered)
- d_we  out  1  write enable (registered)
- d_addr  out  ADDRESS_BITS  byte address = ALU_result[ADDRESS_BITS-1:0] (registered)
- d_be  out  4  byte enables (registered)
- d_wdata  out  DATA_WIDTH  lane-replicated store data (registered)
- d_ready  in  1  memory completes request this cycle
- d_rdata  in  DATA_WIDTH  read word, valid when d_ready=1
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not capture
- mem_misaligned  out  1  misaligned or illegal-funct3 access this cycle
- mem_bus_error  out  1  one-cycle pulse on timeout abort
- mem_regWrite  out  1  to MEM/WB
- mem_memRead  out  1  to MEM/WB
- mem_rd  out  5  to MEM/WB
- mem_memory_data  out  DATA_WIDTH  extended load data to MEM/WB (registered)
- mem_ALU_result  out  DATA_WIDTH  pass-through of ex_ALU_result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; d_req, d_we, d_addr, d_be, d_wdata, mem_memory_data, mem_bus_error and the timeout counter all 0. mem_stall is forced 0 while reset=0.
- A reset during WAIT abandons the access; d_req drops immediately.
- access = ex_memRead | ex_memWrite.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal: access with funct3 not in {000,001,010,100,101}.
- Misaligned or illegal: mem_misaligned=1 (combinational), no request, mem_regWrite forced 0, mem_stall=0.
- Non-access instructions pass through combinationally with mem_stall=0. mem_regWrite, mem_memRead, mem_rd and mem_ALU_result always follow ex_* inputs (except the squash above).
- FSM IDLE:
  - A valid access drives mem_stall=1.
  - At the clock edge: load d_req=1, d_we=ex_memWrite, d_addr, d_be and d_wdata; go to WAIT.
- FSM WAIT:
  - mem_stall=1 and all d_* signals are held stable.
  - On d_ready=1 at the edge: d_req=0; for loads, register extended data into mem_memory_data; go to DONE.
- FSM DONE:
  - mem_stall=0; the instruction advances into MEM/WB at this edge; return to IDLE.
  - No new request is issued from DONE.
- Stall latency: a zero-wait memory (d_ready in the first WAIT cycle) gives 2 stall cycles; each extra wait cycle adds 1.
- Byte enables:
  - B/BU: 1<<addr[1:0].
  - H/HU: 0011 or 1100 by addr[1].
  - W: 1111.
- Store data: SB replicates the byte to all 4 lanes; SH replicates the halfword to both halves; SW is passed as is. d_wdata is 0 for loads.
- Load extension: select the lane by addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through. Little-endian.
- mem_memory_data holds its value until the next completed load.
- d_ready outside WAIT is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without d_ready: drop d_req, set mem_memory_data=0, pulse mem_bus_error for 1 cycle, force mem_regWrite=0 in DONE, go to DONE.
  - d_ready arriving on the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; WAIT waits indefinitely; mem_bus_error is tied to 0.

Test Plan:
- Reset: hold reset=0 with ex_memRead=1 → mem_stall=0, d_req=0, mem_memory_data=0; release reset → d_req=1 on the next edge.
- LB at addr 0x00003, d_rdata=0x80FF1234, ready in the first WAIT cycle → 2 stall cycles, mem_memory_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at addr 0x00002, store_data=0x0000BEEF, 3 wait cycles → d_be=1100, d_wdata=0xBEEFBEEF, d_we=1, mem_stall high for 5 cycles.
- LW at addr 0x00006 → mem_misaligned=1, d_req stays 0, mem_regWrite=0, no stall.
- Back-to-back LW 0x10 then SW 0x14 with zero-wait memory → two separate 2-cycle stalls; d_req deasserted in between (DONE cycle); the ALU instruction between them passes with mem_stall=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and d_ready held 0 → d_req drops after 4 WAIT cycles, mem_bus_error 1-cycle pulse, mem_memory_data=0, mem_regWrite=0.
